// File: rtl/rsa_job_scheduler.sv
// Round-robin front end sharing one RSA modular-exponentiation engine between
// NREQ requesters; no job is granted until key generation reports done.
module rsa_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int W       = 7,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_done,
  input  logic [W-1:0]            e,
  input  logic [W-1:0]            d,
  input  logic [W-1:0]            n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    eng_start,
  output logic [W-1:0]            eng_base,
  output logic [W-1:0]            eng_exp,
  output logic [W-1:0]            eng_mod,
  input  logic                    eng_done,
  input  logic [W-1:0]            eng_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  next_ptr;
  logic            any_req;
  logic [W-1:0]    sel_data;
  logic            sel_op;
  logic            accept;
  logic            reject;
  logic            timeout_hit;
  logic [CW-1:0]   cnt;

  // Round-robin scan starting at rr_ptr; lowest offset wins, hence the reverse loop.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      idx = sum[IDW-1:0];
      if (req_valid[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  assign sel_data    = req_data[grant*W +: W];
  assign sel_op      = req_op[grant];
  assign accept      = |(req_valid & req_ready);
  assign reject      = (sel_data >= n);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign next_ptr    = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = reject ? RESP : ISSUE;
      ISSUE: state_nx = BUSY;
      BUSY:  if (eng_done || timeout_hit) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && key_done && any_req && !reset) req_ready[grant] = 1'b1;
    eng_start = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Operands and response fields; the response is prefilled as an error on
  // reject so the IDLE->RESP shortcut needs no further update.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      eng_base <= '0;
      eng_exp  <= '0;
      eng_mod  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        eng_base <= sel_data;
        eng_exp  <= sel_op ? d : e;
        eng_mod  <= n;
        rsp_id   <= grant;
        rsp_data <= '0;
        rsp_err  <= reject;
        rr_ptr   <= next_ptr;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        if (eng_done) begin
          rsp_data <= eng_result;
          rsp_err  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule
